// File: rtl/fifo_reader_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg -- shared definitions for the FIFO reader slice.
//   DATA_WIDTH_DEFAULT : default data word width
//   COUNT_WIDTH        : width of the optional downstream transfer counter
//   occ_t              : occupancy of the 2-entry output buffer
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT = 8;
    localparam int unsigned COUNT_WIDTH        = 16;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

endpackage

// File: rtl/fifo_reader_skid.sv
// -----------------------------------------------------------------------------
// fifo_reader_skid -- 2-entry output buffer for fifo_reader.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   flush          : synchronous discard of both entries (wins over push/pop)
//   push/push_data : write a word behind the current contents
//   pop            : head word consumed downstream (only meaningful when valid)
//   occupancy      : current entry count
//   out_valid      : buffer not empty
//   out_data       : oldest entry
// -----------------------------------------------------------------------------
module fifo_reader_skid
    import fifo_pkg::*;
#(
    parameter int unsigned data_width = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [data_width-1:0] push_data,
    input  logic                  pop,
    output occ_t                  occupancy,
    output logic                  out_valid,
    output logic [data_width-1:0] out_data
);

    occ_t                  r_occ;
    occ_t                  w_occ_next;
    logic [data_width-1:0] r_head;
    logic [data_width-1:0] r_tail;
    logic                  w_pop;

    assign w_pop = pop && (r_occ != OCC_EMPTY);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_occ <= OCC_EMPTY;
        end else begin
            r_occ <= w_occ_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_occ_next = r_occ;
        if (flush) begin
            w_occ_next = OCC_EMPTY;
        end else if (push && !w_pop) begin
            case (r_occ)
                OCC_EMPTY: w_occ_next = OCC_ONE;
                default:   w_occ_next = OCC_TWO;
            endcase
        end else if (!push && w_pop) begin
            case (r_occ)
                OCC_TWO: w_occ_next = OCC_ONE;
                default: w_occ_next = OCC_EMPTY;
            endcase
        end
    end

    // Entry storage: head is always the oldest word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (!flush) begin
            if (push && w_pop) begin
                // Simultaneous capture and transfer: new word queues behind the survivor
                if (r_occ == OCC_TWO) begin
                    r_head <= r_tail;
                    r_tail <= push_data;
                end else begin
                    r_head <= push_data;
                end
            end else if (push) begin
                if (r_occ == OCC_EMPTY) begin
                    r_head <= push_data;
                end else if (r_occ == OCC_ONE) begin
                    r_tail <= push_data;
                end
            end else if (w_pop) begin
                r_head <= r_tail;
            end
        end
    end

    // Outputs
    always_comb begin
        occupancy = r_occ;
        out_valid = (r_occ != OCC_EMPTY);
        out_data  = r_head;
    end

endmodule

// File: rtl/fifo_reader.sv
// -----------------------------------------------------------------------------
// fifo_reader -- pops a synchronous-read FIFO (data one cycle after the pop)
// and presents the words on a valid/ready interface through a 2-entry buffer.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   fifo_read_enable  : pop request to the FIFO
//   fifo_read_data    : FIFO word, valid the cycle after an accepted pop
//   fifo_read_empty   : FIFO empty
//   out_valid/out_data/out_ready : downstream handshake
//   flush             : synchronous discard of buffered and in-flight data
//   pop_count         : downstream transfer count (only with FIFO_READER_COUNT_EN)
// Build option: define FIFO_READER_COUNT_EN to add the pop_count output.
// -----------------------------------------------------------------------------
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int unsigned data_width = DATA_WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    output logic                   fifo_read_enable,
    input  logic [data_width-1:0]  fifo_read_data,
    input  logic                   fifo_read_empty,
    output logic                   out_valid,
    output logic [data_width-1:0]  out_data,
`ifdef FIFO_READER_COUNT_EN
    output logic [COUNT_WIDTH-1:0] pop_count,
`endif
    input  logic                   out_ready,
    input  logic                   flush
);

    occ_t       w_occ;
    logic       w_out_valid;
    logic       w_pop_out;
    logic       w_pop_accept;
    logic       w_capture;
    logic [2:0] w_level;
    logic       r_inflight;

    assign w_pop_out = w_out_valid && out_ready;

    // Slots committed after this edge; a transfer this cycle frees one
    assign w_level = 3'(w_occ) + 3'(r_inflight) - 3'(w_pop_out);

    // reset_n gates the request so no pop is issued while reset is held
    assign fifo_read_enable = reset_n && !fifo_read_empty && !flush && (w_level < 3'd2);
    assign w_pop_accept     = fifo_read_enable && !fifo_read_empty;
    assign w_capture        = r_inflight && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight <= 1'b0;
        end else if (flush) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_pop_accept;
        end
    end

    fifo_reader_skid #(
        .data_width (data_width)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .push      (w_capture),
        .push_data (fifo_read_data),
        .pop       (w_pop_out),
        .occupancy (w_occ),
        .out_valid (w_out_valid),
        .out_data  (out_data)
    );

    assign out_valid = w_out_valid;

`ifdef FIFO_READER_COUNT_EN
    logic [COUNT_WIDTH-1:0] r_pop_count;

    // Counts every downstream handshake; flush does not touch it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pop_count <= '0;
        end else if (w_pop_out) begin
            r_pop_count <= r_pop_count + COUNT_WIDTH'(1);
        end
    end

    assign pop_count = r_pop_count;
`endif

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter data_width, default 8, the width of the data word on both sides.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port fifo_read_enable  output  1  pop request to the upstream FIFO read side.
REQ-005 SHALL have port fifo_read_data  input  data_width  FIFO read word, valid exactly one cycle after an accepted pop.
REQ-006 SHALL have port fifo_read_empty  input  1  FIFO-empty indication.
REQ-007 SHALL have port out_valid  output  1  downstream word available.
REQ-008 SHALL have port out_data  output  data_width  downstream word.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-010 SHALL have port flush  input  1  synchronous discard of all buffered and in-flight data.

Function
REQ-011 SHALL treat a pop as accepted in any cycle where fifo_read_enable=1 and fifo_read_empty=0.
REQ-012 SHALL set an in-flight flag on an accepted pop and, on the next edge, capture fifo_read_data into the output buffer.
REQ-013 SHALL hold a 2-entry output buffer with occupancy states EMPTY(0), ONE(1) and TWO(2).
REQ-014 SHALL drive fifo_read_enable = !fifo_read_empty && !flush && (occupancy + inflight - pop_out) < 2, where pop_out = out_valid && out_ready in the same cycle.
REQ-015 SHALL drive out_valid = (occupancy != EMPTY); out_data SHALL be the oldest entry.
REQ-016 SHALL complete a downstream transfer on any edge where out_valid && out_ready.
REQ-017 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-018 SHALL make these state transitions: capture only -> occupancy+1; transfer only -> occupancy-1; capture and transfer in the same cycle -> occupancy unchanged, the new word is queued behind the remaining entry.
REQ-019 SHALL sustain one word per cycle when the FIFO is non-empty and out_ready is held at 1, after a 2-cycle initial latency from pop to out_valid.
REQ-020 SHALL preserve FIFO order exactly, with no drop or duplication, under any pattern of out_ready.
REQ-021 SHALL never overflow the buffer: in-flight plus occupancy is at most 2 at all times.
REQ-022 SHALL, when flush=1 at an edge, set occupancy to EMPTY, clear in-flight and discard the word returning that edge; fifo_read_enable SHALL be 0 during the flush cycle.
REQ-023 SHALL give flush priority over capture and over transfer in the same cycle.

Reset
REQ-024 SHALL, while reset_n=0, force fifo_read_enable=0, out_valid=0, out_data=0, occupancy=EMPTY, in-flight=0, and the count (if present) to 0, independent of clk.
REQ-025 SHALL discard any in-flight word if reset is asserted mid-operation; first pop SHALL be no earlier than the first edge after reset_n rises.

Configuration
REQ-026 SHALL, with macro FIFO_READER_COUNT_EN defined, add output pop_count [15:0] that increments on each downstream transfer, wraps 65535->0, and is unaffected by flush.
REQ-027 SHALL, without FIFO_READER_COUNT_EN, have no pop_count port, no counter logic, and function otherwise identical.

Structure
REQ-028 SHALL place the following in shared package fifo_pkg: the default data width constant, the count width constant (16), and the occupancy state enumeration.
REQ-029 SHALL implement the 2-entry buffer as sub-module fifo_reader_skid; pop control, in-flight tracking and the counter SHALL remain in fifo_reader.

Verification
REQ-030 SHALL cover streaming: FIFO preloaded 0x01..0x08, out_ready=1 -> out_data 0x01..0x08 on 8 consecutive cycles, first out_valid 2 cycles after the first pop.
REQ-031 SHALL cover backpressure: out_ready=0 with 5 words queued -> exactly 2 pops, out_data held at 0x01; on release -> remaining words in order, none lost.
REQ-032 SHALL cover an empty FIFO: fifo_read_empty=1 -> fifo_read_enable=0 and out_valid=0 indefinitely; a single write of 0xA5 -> one pop, then out_data=0xA5.
REQ-033 SHALL cover flush: flush asserted with occupancy TWO and a word in flight -> next cycle out_valid=0, and the following word delivered is the next FIFO entry.
REQ-034 SHALL cover reset mid-stream: reset_n driven low between edges -> outputs 0 immediately; the stream restarts cleanly after release.
REQ-035 SHALL cover the counter (FIFO_READER_COUNT_EN): 65537 transfers -> pop_count=1.
